// File: rtl/sd_spi_init_ctrl.sv
// SD card SPI-mode init sequencer: CMD0, CMD8, CMD55/CMD41 loop, CMD58.
// Drives a byte-wide SPI engine one transfer at a time.
module sd_spi_init_ctrl #(
  parameter int NCR_MAX   = 8,
  parameter int RETRY_MAX = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_cs,
  output logic       o_xfer_valid,
  output logic [7:0] o_xfer_data,
  input  logic       i_xfer_ready,
  input  logic       i_resp_valid,
  input  logic [7:0] i_resp_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [2:0] o_err_code,
  output logic       o_sdhc
);

  typedef enum logic [2:0] {
    IDLE, DUMMY, CMD_TX, R1_POLL, R_DATA, GAP, DONE, ERR
  } state_t;

  typedef enum logic [2:0] {C0, C8, C55, C41, C58} cmd_t;
  typedef enum logic [1:0] {EV_NEXT, EV_DONE, EV_ERR} ev_t;

  state_t      state;
  cmd_t        cmd;
  logic [3:0]  cnt;
  logic [15:0] ncr;
  logic [15:0] retry;
  logic [15:0] retry_inc;
  logic [7:0]  r1_q;
  logic [7:0]  r1v;
  logic        ccs_q;
  logic [3:0]  nib_q;
  logic        pend;
  logic [47:0] frame;
  logic [7:0]  tx_byte;
  logic [2:0]  cmd_code;
  ev_t         ev;
  cmd_t        ev_cmd;
  logic [2:0]  ev_code;
  logic        ev_retry;
  logic        rx;
  logic        do_eval;
  logic        timeout;

  always_comb begin
    case (cmd)
      C0:      frame = 48'h40_0000_0000_95;
      C8:      frame = 48'h48_0000_01AA_87;
      C55:     frame = 48'h77_0000_0000_65;
      C41:     frame = 48'h69_4000_0000_77;
      C58:     frame = 48'h7A_0000_0000_FD;
      default: frame = '1;
    endcase
  end

  always_comb begin
    tx_byte = 8'hFF;
    if (state == CMD_TX) begin
      case (cnt)
        4'd0:    tx_byte = frame[47:40];
        4'd1:    tx_byte = frame[39:32];
        4'd2:    tx_byte = frame[31:24];
        4'd3:    tx_byte = frame[23:16];
        4'd4:    tx_byte = frame[15:8];
        default: tx_byte = frame[7:0];
      endcase
    end
  end

  always_comb begin
    case (cmd)
      C0:      cmd_code = 3'd1;
      C8:      cmd_code = 3'd2;
      C58:     cmd_code = 3'd4;
      default: cmd_code = 3'd3;
    endcase
  end

  // A response byte is consumed only once its byte has been accepted
  assign rx = pend && !o_xfer_valid && i_resp_valid;

  assign do_eval = rx &&
    ((state == R1_POLL && i_resp_data != 8'hFF &&
      cmd != C8 && cmd != C58) ||
     (state == R_DATA && cnt == 4'd3));

  assign timeout = rx && state == R1_POLL &&
    i_resp_data == 8'hFF && int'(ncr) >= NCR_MAX - 1;

  assign r1v       = (state == R1_POLL) ? i_resp_data : r1_q;
  assign retry_inc = (&retry) ? retry : retry + 16'd1;

  always_comb begin
    ev       = EV_ERR;
    ev_cmd   = cmd;
    ev_code  = cmd_code;
    ev_retry = 1'b0;
    case (cmd)
      C0: if (r1v == 8'h01) begin
        ev = EV_NEXT; ev_cmd = C8;
      end
      C8: if (r1v == 8'h01 && nib_q == 4'h1 &&
              i_resp_data == 8'hAA) begin
        ev = EV_NEXT; ev_cmd = C55;
      end
      C55: if (r1v == 8'h00 || r1v == 8'h01) begin
        ev = EV_NEXT; ev_cmd = C41;
      end
      C41: begin
        if (r1v == 8'h00) begin
          ev = EV_NEXT; ev_cmd = C58;
        end else if (r1v == 8'h01) begin
          ev_retry = 1'b1;
          if (int'(retry_inc) < RETRY_MAX) begin
            ev = EV_NEXT; ev_cmd = C55;
          end
        end
      end
      C58: if (r1v == 8'h00) ev = EV_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cmd          <= C0;
      cnt          <= '0;
      ncr          <= '0;
      retry        <= '0;
      r1_q         <= '0;
      ccs_q        <= 1'b0;
      nib_q        <= '0;
      pend         <= 1'b0;
      o_cs         <= 1'b1;
      o_xfer_valid <= 1'b0;
      o_xfer_data  <= 8'hFF;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= '0;
      o_sdhc       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state      <= DUMMY;
            o_busy     <= 1'b1;
            o_cs       <= 1'b1;
            o_err_code <= '0;
            o_sdhc     <= 1'b0;
            retry      <= '0;
            ncr        <= '0;
            cnt        <= '0;
            cmd        <= C0;
            pend       <= 1'b0;
          end
        end
        DONE, ERR: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          if (o_xfer_valid) begin
            if (i_xfer_ready) begin
              o_xfer_valid <= 1'b0;
              pend         <= 1'b1;
            end
          end else if (!pend) begin
            o_xfer_valid <= 1'b1;
            o_xfer_data  <= tx_byte;
          end else if (i_resp_valid) begin
            pend <= 1'b0;
            case (state)
              DUMMY: begin
                if (cnt == 4'd9) begin
                  cnt   <= '0;
                  state <= CMD_TX;
                  o_cs  <= 1'b0;
                end else begin
                  cnt <= cnt + 4'd1;
                end
              end
              CMD_TX: begin
                if (cnt == 4'd5) begin
                  cnt   <= '0;
                  ncr   <= '0;
                  state <= R1_POLL;
                end else begin
                  cnt <= cnt + 4'd1;
                end
              end
              R1_POLL: begin
                if (i_resp_data == 8'hFF) begin
                  ncr <= ncr + 16'd1;
                end else begin
                  r1_q <= i_resp_data;
                  if (cmd == C8 || cmd == C58) begin
                    state <= R_DATA;
                    cnt   <= '0;
                  end
                end
              end
              R_DATA: begin
                cnt <= cnt + 4'd1;
                if (cnt == 4'd0) ccs_q <= i_resp_data[6];
                if (cnt == 4'd2) nib_q <= i_resp_data[3:0];
              end
              GAP: begin
                state <= CMD_TX;
                o_cs  <= 1'b0;
                cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
      endcase

      if (timeout) begin
        state      <= ERR;
        o_err      <= 1'b1;
        o_err_code <= cmd_code;
        o_cs       <= 1'b1;
        o_sdhc     <= 1'b0;
      end

      // Command verdict once R1 (and any trailing data) is in
      if (do_eval) begin
        if (ev_retry) retry <= retry_inc;
        o_cs <= 1'b1;
        case (ev)
          EV_NEXT: begin
            cmd   <= ev_cmd;
            state <= GAP;
          end
          EV_DONE: begin
            state  <= DONE;
            o_done <= 1'b1;
            o_sdhc <= ccs_q;
          end
          default: begin
            state      <= ERR;
            o_err      <= 1'b1;
            o_err_code <= ev_code;
            o_sdhc     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_init_ctrl.sv
// Bench for sd_spi_init_ctrl: SPI engine plus SD card model,
// table of card behaviours and a mid-command reset sequence.
module tb_sd_spi_init_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cs;
  logic       xv;
  logic [7:0] xd;
  logic       ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] code;
  logic       sdhc;

  sd_spi_init_ctrl #(.NCR_MAX(8), .RETRY_MAX(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .o_cs         (cs),
    .o_xfer_valid (xv),
    .o_xfer_data  (xd),
    .i_xfer_ready (ready),
    .i_resp_valid (resp_valid),
    .i_resp_data  (resp_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_err_code   (code),
    .o_sdhc       (sdhc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          nocard;
    int          ncr;
    logic [31:0] echo;
    int          n41;
    logic [31:0] ocr;
    logic [7:0]  r1_58;
    int          stall_at;
    bit          start_mid;
    bit          exp_done;
    logic [2:0]  exp_code;
    bit          exp_sdhc;
    int          exp_n55;
    int          exp_n58;
    int          exp_cshi;
    int          exp_total;
  } vec_t;

  vec_t vecs[9];
  vec_t cur;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] frame[6];
  logic [7:0] rq[16];
  int frame_cnt, rq_len, rq_idx, n41_left;
  bit seen_low;
  int n0, n8, n55, n41, n58, frame_bad, proto_bad;
  int dummy_cnt, cshi_cnt, total_cnt, done_cyc, err_cyc;
  logic pulse_cs;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    frame_cnt = 0; rq_len = 0; rq_idx = 0; seen_low = 0;
    n41_left = cur.n41;
    n0 = 0; n8 = 0; n55 = 0; n41 = 0; n58 = 0;
    frame_bad = 0; proto_bad = 0;
    dummy_cnt = 0; cshi_cnt = 0; total_cnt = 0;
    done_cyc = 0; err_cyc = 0; pulse_cs = 1'b0;
  endtask

  task automatic decode();
    logic [47:0] f, want;
    logic [7:0]  r1;
    logic [31:0] d;
    bit          dat;
    f = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
    want = '0; r1 = 8'h01; dat = 0; d = '0;
    case (frame[0])
      8'h40: begin n0++; want = 48'h400000000095; end
      8'h48: begin
        n8++; want = 48'h48000001AA87; dat = 1; d = cur.echo;
      end
      8'h77: begin n55++; want = 48'h770000000065; end
      8'h69: begin
        n41++; want = 48'h694000000077;
        if (n41_left > 0) n41_left--;
        else r1 = 8'h00;
      end
      8'h7A: begin
        n58++; want = 48'h7A00000000FD;
        r1 = cur.r1_58; dat = 1; d = cur.ocr;
      end
      default: ;
    endcase
    if (f !== want) frame_bad++;
    rq_len = 0; rq_idx = 0;
    for (int i = 0; i < cur.ncr; i++) begin
      rq[rq_len] = 8'hFF; rq_len++;
    end
    rq[rq_len] = r1; rq_len++;
    if (dat)
      for (int i = 0; i < 4; i++) begin
        rq[rq_len] = d[31-8*i -: 8]; rq_len++;
      end
  endtask

  task automatic card_byte(input logic [7:0] b, input logic c,
                           output logic [7:0] r);
    total_cnt++;
    r = 8'hFF;
    if (c) begin
      frame_cnt = 0; rq_len = 0; rq_idx = 0;
      cshi_cnt++;
      if (!seen_low) dummy_cnt++;
    end else begin
      seen_low = 1;
      if (frame_cnt < 6) begin
        frame[frame_cnt] = b;
        frame_cnt++;
        if (frame_cnt == 6) decode();
      end else if (rq_idx < rq_len) begin
        r = rq[rq_idx]; rq_idx++;
      end
    end
    if (cur.nocard) r = 8'hFF;
  endtask

  task automatic run(input bit abort41, output bit aborted);
    logic pv, pr, pc;
    logic [7:0] pd, r;
    bit fin;
    model_reset();
    aborted = 0; fin = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({cur.name, ":start_busy"}, busy, 1);
    chk({cur.name, ":start_code"}, code, 0);
    chk({cur.name, ":start_sdhc"}, sdhc, 0);
    ready = 1'b1;
    pv = xv; pd = xd; pc = cs; pr = ready;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (done) begin done_cyc++; pulse_cs = cs; end
      if (err) begin err_cyc++; pulse_cs = cs; end
      if (pv && pr) begin
        if (xv) proto_bad++;
        card_byte(pd, pc, r);
        resp_valid = 1'b1;
        resp_data  = r;
      end else if (pv && (!xv || xd !== pd)) begin
        proto_bad++;
      end
      ready = !(cur.stall_at > 0 && cyc >= cur.stall_at &&
                cyc < cur.stall_at + 20);
      start = cur.start_mid && cyc == cur.stall_at + 5;
      if (abort41 && frame_cnt == 2 && frame[0] == 8'h69) begin
        aborted = 1; fin = 1;
      end else if (!busy) begin
        fin = 1;
      end
      pv = xv; pd = xd; pc = cs; pr = ready;
    end
    start = 1'b0;
    if (!aborted) resp_valid = 1'b0;
    chk({cur.name, ":finished"}, fin, 1);
  endtask

  task automatic check_vec();
    chk({cur.name, ":done_pulses"}, done_cyc, cur.exp_done);
    chk({cur.name, ":err_pulses"}, err_cyc, !cur.exp_done);
    chk({cur.name, ":pulse_cs"}, pulse_cs, 1);
    chk({cur.name, ":err_code"}, code, cur.exp_code);
    chk({cur.name, ":sdhc"}, sdhc, cur.exp_sdhc);
    chk({cur.name, ":busy_end"}, busy, 0);
    chk({cur.name, ":n_cmd0"}, n0, 1);
    chk({cur.name, ":n_cmd55"}, n55, cur.exp_n55);
    chk({cur.name, ":n_cmd41"}, n41, cur.exp_n55);
    chk({cur.name, ":n_cmd58"}, n58, cur.exp_n58);
    chk({cur.name, ":dummy_bytes"}, dummy_cnt, 10);
    chk({cur.name, ":cs_high_bytes"}, cshi_cnt, cur.exp_cshi);
    chk({cur.name, ":total_bytes"}, total_cnt, cur.exp_total);
    chk({cur.name, ":frame_errs"}, frame_bad, 0);
    chk({cur.name, ":handshake_errs"}, proto_bad, 0);
  endtask

  initial begin
    bit ab;
    vecs[0] = '{"nominal", 0, 1, 32'h000001AA, 2, 32'hC0FF8000,
                8'h00, 0, 0, 1, 3'd0, 1, 3, 1, 18, 98};
    vecs[1] = '{"nocard", 1, 1, 32'h000001AA, 0, 32'hC0FF8000,
                8'h00, 0, 0, 0, 3'd1, 0, 0, 0, 10, 24};
    vecs[2] = '{"echo_ab", 0, 1, 32'h000001AB, 0, 32'hC0FF8000,
                8'h00, 0, 0, 0, 3'd2, 0, 0, 0, 11, 31};
    vecs[3] = '{"acmd41_busy", 0, 1, 32'h000001AA, 1000, 32'hC0FF8000,
                8'h00, 0, 0, 0, 3'd3, 0, 4, 0, 19, 103};
    vecs[4] = '{"sdsc", 0, 1, 32'h000001AA, 0, 32'h80FF8000,
                8'h00, 0, 0, 1, 3'd0, 0, 1, 1, 14, 62};
    vecs[5] = '{"cmd58_bad", 0, 1, 32'h000001AA, 0, 32'hC0FF8000,
                8'h05, 0, 0, 0, 3'd4, 0, 1, 1, 14, 62};
    vecs[6] = '{"ncr7", 0, 7, 32'h000001AA, 0, 32'hC0FF8000,
                8'h00, 0, 0, 1, 3'd0, 1, 1, 1, 14, 92};
    vecs[7] = '{"ncr8", 0, 8, 32'h000001AA, 0, 32'hC0FF8000,
                8'h00, 0, 0, 0, 3'd1, 0, 0, 0, 10, 24};
    vecs[8] = '{"stall", 0, 1, 32'h000001AA, 2, 32'hC0FF8000,
                8'h00, 30, 1, 1, 3'd0, 1, 3, 1, 18, 98};

    rst = 1'b1; start = 1'b0; ready = 1'b1;
    resp_valid = 1'b0; resp_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset:cs", cs, 1);
    chk("reset:xfer_valid", xv, 0);
    chk("reset:xfer_data", xd, 8'hFF);
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:err", err, 0);
    chk("reset:err_code", code, 0);
    chk("reset:sdhc", sdhc, 0);

    for (int i = 0; i < 9; i++) begin
      cur = vecs[i];
      run(0, ab);
      repeat (3) @(negedge clk);
      check_vec();
    end

    cur = vecs[0];
    cur.name = "reset_in_cmd41";
    run(1, ab);
    chk("rst41:reached", ab, 1);
    chk("rst41:cs_before", cs, 0);
    rst = 1'b1;
    #1;
    chk("rst41:cs", cs, 1);
    chk("rst41:busy", busy, 0);
    chk("rst41:xfer_valid", xv, 0);
    chk("rst41:xfer_data", xd, 8'hFF);
    @(negedge clk);
    rst = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    resp_valid = 1'b1; resp_data = 8'h00;
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst41:idle_busy", busy, 0);
    chk("rst41:idle_valid", xv, 0);
    chk("rst41:idle_cs", cs, 1);

    cur = vecs[0];
    cur.name = "after_reset";
    run(0, ab);
    repeat (3) @(negedge clk);
    check_vec();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
